// File: rtl/speed_ctrl_if.sv
// -----------------------------------------------------------------------------
// speed_ctrl_if
// Purpose : Bundles the key-pulse inputs and the run-control outputs of
//           speed_ctrl. The clock and reset are plain module ports and are not
//           part of this interface.
// Signals : Key_pause  1      one-cycle pulse, toggle pause
//           Key_up     1      one-cycle pulse, level +1 (faster)
//           Key_down   1      one-cycle pulse, level -1 (slower)
//           tick       1      registered one-cycle clock-enable pulse
//           paused     1      1 = ticking halted
//           level      LVL_W  current speed level
// Modports: master - key source / consumer of the run-control state
//           slave  - speed_ctrl itself
// -----------------------------------------------------------------------------
interface speed_ctrl_if #(
   parameter int LVL_W = 3
);
   logic             Key_pause;
   logic             Key_up;
   logic             Key_down;
   logic             tick;
   logic             paused;
   logic [LVL_W-1:0] level;

   modport master (
      output Key_pause, Key_up, Key_down,
      input  tick, paused, level
   );

   modport slave (
      input  Key_pause, Key_up, Key_down,
      output tick, paused, level
   );
endinterface

// File: rtl/speed_ctrl.sv
// -----------------------------------------------------------------------------
// speed_ctrl
// Purpose : Turns debounced key pulses into run-control state: a paused flag,
//           a speed level and a one-cycle clock-enable tick whose period is
//           BASE_DIV >> level clocks.
// Ports   : Clk_50mhz  in   system clock
//           Rst        in   synchronous, active-high reset
//           io         slave modport of speed_ctrl_if
//                      (Key_pause/Key_up/Key_down in, tick/paused/level out)
// Params  : BASE_DIV      tick period at level 0, (BASE_DIV >> (LEVELS-1)) >= 2
//           LEVELS        number of speed levels, 2..16
//           DEFAULT_LEVEL level loaded on reset
// Option  : SPEED_CTRL_SINGLE_STEP_EN - when defined, Key_up while paused
//           issues a single tick instead of raising the level.
// -----------------------------------------------------------------------------
module speed_ctrl #(
   parameter int BASE_DIV      = 50_000_000,
   parameter int LEVELS        = 8,
   parameter int DEFAULT_LEVEL = 0
) (
   input  logic          Clk_50mhz,
   input  logic          Rst,
   speed_ctrl_if.slave   io
);
   localparam int CNT_W = $clog2(BASE_DIV);
   localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(LEVELS - 1);
   localparam logic [LVL_W-1:0] DEF_LVL = LVL_W'(DEFAULT_LEVEL);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_tick;
   logic [LVL_W-1:0] r_level;
   logic [CNT_W-1:0] r_cnt;

   logic             w_up_only;
   logic             w_down_only;
   logic             w_up_lvl;
   logic             w_step;
   logic             w_inc;
   logic             w_dec;
   logic             w_lvl_change;
   logic [CNT_W-1:0] w_period;
   logic [CNT_W-1:0] w_period_m1;
   logic             w_wrap;

   // Simultaneous up and down cancel each other entirely.
   assign w_up_only   = io.Key_up & ~io.Key_down;
   assign w_down_only = io.Key_down & ~io.Key_up;

`ifdef SPEED_CTRL_SINGLE_STEP_EN
   // While paused, Key_up becomes a single-step request rather than a speed-up.
   assign w_step   = w_up_only & (r_state == ST_PAUSE);
   assign w_up_lvl = w_up_only & (r_state == ST_RUN);
`else
   assign w_step   = 1'b0;
   assign w_up_lvl = w_up_only;
`endif

   // Saturated presses are no-ops and must not disturb the counter.
   assign w_inc        = w_up_lvl & (r_level != MAX_LVL);
   assign w_dec        = w_down_only & (r_level != '0);
   assign w_lvl_change = w_inc | w_dec;

   // Truncation to CNT_W is intentional: a power-of-two BASE_DIV at level 0
   // wraps to 0 here and period-1 becomes all ones, which is the right terminal.
   assign w_period    = CNT_W'(BASE_DIV >> r_level);
   assign w_period_m1 = w_period - CNT_W'(1);
   assign w_wrap      = (r_cnt == w_period_m1);

   always_ff @(posedge Clk_50mhz) begin
      if (Rst) begin
         r_state <= ST_RUN;
         r_tick  <= 1'b0;
         r_level <= DEF_LVL;
         r_cnt   <= '0;
      end else begin
         if (w_inc) begin
            r_level <= r_level + LVL_W'(1);
         end else if (w_dec) begin
            r_level <= r_level - LVL_W'(1);
         end

         case (r_state)
            ST_RUN: begin
               if (io.Key_pause) begin
                  r_state <= ST_PAUSE;
               end
               if (w_lvl_change) begin
                  r_cnt  <= '0;
                  r_tick <= 1'b0;
               end else if (io.Key_pause) begin
                  // Pausing freezes this edge too, so a coincident wrap is
                  // deferred until the resume.
                  r_tick <= 1'b0;
               end else if (w_wrap) begin
                  r_cnt  <= '0;
                  r_tick <= 1'b1;
               end else begin
                  r_cnt  <= r_cnt + CNT_W'(1);
                  r_tick <= 1'b0;
               end
            end
            ST_PAUSE: begin
               // Counting restarts only on the edge after the resume edge.
               if (io.Key_pause) begin
                  r_state <= ST_RUN;
               end
               if (w_lvl_change) begin
                  r_cnt  <= '0;
                  r_tick <= 1'b0;
               end else begin
                  r_tick <= w_step;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_tick  <= 1'b0;
            end
         endcase
      end
   end

   assign io.tick   = r_tick;
   assign io.paused = (r_state == ST_PAUSE);
   assign io.level  = r_level;

endmodule

// File: tb/tb_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_speed_ctrl
// Purpose : Self-checking bench for speed_ctrl with BASE_DIV=16, LEVELS=4,
//           DEFAULT_LEVEL=0. Table vectors, hand-written timing sequences and a
//           randomized run against a countdown-based reference model.
// Option  : honours SPEED_CTRL_SINGLE_STEP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_speed_ctrl;
   localparam int BASE_DIV      = 16;
   localparam int LEVELS        = 4;
   localparam int DEFAULT_LEVEL = 0;
   localparam int LVL_W         = 2;

   logic Clk_50mhz = 1'b0;
   logic Rst       = 1'b1;

   speed_ctrl_if #(.LVL_W(LVL_W)) bus ();

   speed_ctrl #(
      .BASE_DIV      (BASE_DIV),
      .LEVELS        (LEVELS),
      .DEFAULT_LEVEL (DEFAULT_LEVEL)
   ) dut (
      .Clk_50mhz (Clk_50mhz),
      .Rst       (Rst),
      .io        (bus)
   );

   always #5 Clk_50mhz = ~Clk_50mhz;

   int checks = 0;
   int errors = 0;

   // Reference model: m_rem counts clocks remaining until the next tick.
   int m_level  = DEFAULT_LEVEL;
   int m_rem    = BASE_DIV >> DEFAULT_LEVEL;
   bit m_paused = 1'b0;
   bit m_tick   = 1'b0;

   function automatic int period_of(input int lvl);
      return BASE_DIV >> lvl;
   endfunction

   task automatic model_edge(input bit rst, input bit p, input bit u, input bit d);
      int new_lvl;
      bit step;
      if (rst) begin
         m_tick   = 1'b0;
         m_paused = 1'b0;
         m_level  = DEFAULT_LEVEL;
         m_rem    = period_of(DEFAULT_LEVEL);
      end else begin
         step    = 1'b0;
         new_lvl = m_level;
         if (u && !d) begin
`ifdef SPEED_CTRL_SINGLE_STEP_EN
            if (m_paused) step = 1'b1;
            else
`endif
            new_lvl = (m_level < LEVELS - 1) ? m_level + 1 : m_level;
         end
         if (d && !u) new_lvl = (m_level > 0) ? m_level - 1 : 0;
         if (new_lvl != m_level) begin
            m_tick = 1'b0;
            m_rem  = period_of(new_lvl);
         end else if (step) begin
            m_tick = 1'b1;
         end else if (!m_paused && !p) begin
            if (m_rem == 1) begin
               m_tick = 1'b1;
               m_rem  = period_of(m_level);
            end else begin
               m_tick = 1'b0;
               m_rem  = m_rem - 1;
            end
         end else begin
            m_tick = 1'b0;
         end
         m_level  = new_lvl;
         m_paused = m_paused ^ p;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later and
   // compare all outputs against the model.
   task automatic cyc(input bit rst, input bit p, input bit u, input bit d);
      Rst           = rst;
      bus.Key_pause = p;
      bus.Key_up    = u;
      bus.Key_down  = d;
      @(posedge Clk_50mhz);
      #1;
      model_edge(rst, p, u, d);
      chk("model_tick",   int'(bus.tick),   int'(m_tick));
      chk("model_paused", int'(bus.paused), int'(m_paused));
      chk("model_level",  int'(bus.level),  m_level);
   endtask

   // Idle clocks until tick is seen; n = edges taken, or -1 on timeout.
   task automatic edges_to_tick(input int max_edges, output int n);
      n = -1;
      for (int i = 1; i <= max_edges; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.tick) begin
            n = i;
            break;
         end
      end
   endtask

   typedef struct {
      bit rst;
      bit p;
      bit u;
      bit d;
      bit exp_tick;
      bit exp_paused;
      int exp_level;
   } vec_t;

   vec_t vecs[17];

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int tick_cnt;

      bus.Key_pause = 1'b0;
      bus.Key_up    = 1'b0;
      bus.Key_down  = 1'b0;

      //              rst p  u  d   tick paused level
      vecs[0]  = '{1, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{0, 0, 1, 0, 0, 0, 1};
      vecs[2]  = '{0, 0, 1, 0, 0, 0, 2};
      vecs[3]  = '{0, 0, 1, 0, 0, 0, 3};
      vecs[4]  = '{0, 0, 1, 0, 0, 0, 3};  // saturated: cnt keeps counting
      vecs[5]  = '{0, 0, 0, 0, 1, 0, 3};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 3};
      vecs[7]  = '{0, 0, 0, 0, 1, 0, 3};
      vecs[8]  = '{0, 0, 0, 1, 0, 0, 2};
      vecs[9]  = '{0, 0, 1, 1, 0, 0, 2};  // up+down cancel
      vecs[10] = '{0, 1, 0, 0, 0, 1, 2};
      vecs[11] = '{0, 0, 0, 1, 0, 1, 1};  // down accepted while paused
      vecs[12] = '{0, 1, 0, 0, 0, 0, 1};
      vecs[13] = '{0, 0, 1, 0, 0, 0, 2};
      vecs[14] = '{0, 0, 1, 0, 0, 0, 3};  // held key = repeated press
      vecs[15] = '{0, 0, 0, 0, 0, 0, 3};
      vecs[16] = '{0, 0, 0, 0, 1, 0, 3};

      for (int i = 0; i < 17; i++) begin
         cyc(vecs[i].rst, vecs[i].p, vecs[i].u, vecs[i].d);
         chk("vec_tick",   int'(bus.tick),   int'(vecs[i].exp_tick));
         chk("vec_paused", int'(bus.paused), int'(vecs[i].exp_paused));
         chk("vec_level",  int'(bus.level),  vecs[i].exp_level);
         $display("vec %0d rst=%0b p=%0b u=%0b d=%0b -> tick=%0b paused=%0b level=%0d",
                  i, vecs[i].rst, vecs[i].p, vecs[i].u, vecs[i].d,
                  bus.tick, bus.paused, bus.level);
      end

      // Reset release: ticks after edges 16, 32, 48.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_tick", int'(bus.tick), 0);
      chk("rst_level", int'(bus.level), 0);
      chk("rst_paused", int'(bus.paused), 0);
      edges_to_tick(40, n); chk("first_tick_edge", n, 16);
      edges_to_tick(40, n); chk("second_tick_gap", n, 16);
      edges_to_tick(40, n); chk("third_tick_gap", n, 16);
      $display("seq reset_release: ticks at 16/32/48 checked");

      // Two ups -> level 2, period 4; five more -> level 3, period 2.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("two_up_level", int'(bus.level), 2);
      edges_to_tick(20, n); chk("lvl2_first_tick", n, 4);
      edges_to_tick(20, n); chk("lvl2_gap", n, 4);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("sat_up_level", int'(bus.level), 3);
      edges_to_tick(20, n);
      edges_to_tick(20, n); chk("lvl3_gap_a", n, 2);
      edges_to_tick(20, n); chk("lvl3_gap_b", n, 2);
      $display("seq speed_up: level 2/3 spacing checked");

      // Saturated down at level 0 leaves the counter alone.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("sat_down_level", int'(bus.level), 0);
      edges_to_tick(40, n); chk("sat_down_phase", n, 10);
      edges_to_tick(40, n); chk("sat_down_gap", n, 16);
      $display("seq sat_down: phase kept");

      // Pause at cnt=7, hold 100 clocks, resume -> tick 9 clocks later.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("pause_flag", int'(bus.paused), 1);
      tick_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.tick) tick_cnt++;
      end
      chk("pause_no_ticks", tick_cnt, 0);
      chk("pause_still", int'(bus.paused), 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("resume_flag", int'(bus.paused), 0);
      edges_to_tick(30, n); chk("resume_tick", n, 9);
      $display("seq pause_resume: held 100 clocks, resume tick checked");

      // Up+down at level 1 keeps phase; then reset mid-count while paused.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk("updown_level", int'(bus.level), 1);
      edges_to_tick(20, n); chk("updown_phase", n, 4);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("midrst_level", int'(bus.level), 0);
      chk("midrst_paused", int'(bus.paused), 0);
      edges_to_tick(40, n); chk("midrst_tick", n, 16);
      $display("seq updown_and_reset: checked");

      // Key_up while paused.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SPEED_CTRL_SINGLE_STEP_EN
      chk("step_tick", int'(bus.tick), 1);
      chk("step_level", int'(bus.level), 0);
`else
      chk("step_tick", int'(bus.tick), 0);
      chk("step_level", int'(bus.level), 1);
`endif
      chk("step_paused", int'(bus.paused), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("step_tick_after", int'(bus.tick), 0);
      $display("seq paused_up: checked");

      // Randomized run against the model.
      for (int i = 0; i < 4000; i++) begin
         cyc($urandom_range(0, 299) == 0,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 19) == 0);
      end
      $display("seq random: 4000 cycles compared to model");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
